lvds_align_ctrl: RTL and testbench



---
 rtl/lvds_align_ctrl_pkg.sv | 16 +
 rtl/lvds_align_timer.sv | 34 +++
 rtl/lvds_align_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lvds_align_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_align_ctrl_pkg.sv
// rtl/lvds_align_ctrl_pkg.sv - shared state encodings and default constants for lvds_align_ctrl
package lvds_align_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_SETTLE_CYCLES  = 8;
  localparam int DEF_MAX_RETRY      = 3;

endpackage

// File: rtl/lvds_align_timer.sv
// rtl/lvds_align_timer.sv - clear/enable up-counter with terminal-count flag
module lvds_align_timer #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/lvds_align_ctrl.sv
// rtl/lvds_align_ctrl.sv - LVDS aligner training sequencer; LVDS_ALIGN_RELOCK_EN enables retraining on lock loss
module lvds_align_ctrl
  import lvds_align_ctrl_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           train_req,
  input  logic [NUM_LANES-1:0]           lane_lock,
  output logic [NUM_LANES-1:0]           lane_start,
  output logic                           busy,
  output logic                           train_done,
  output logic                           train_fail,
  output logic [NUM_LANES-1:0]           fail_mask,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic                           lock_lost
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [NUM_LANES-1:0] ALL_ONES = {NUM_LANES{1'b1}};

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] lane_start_q, lane_start_d;
  logic                 busy_q, busy_d;
  logic                 train_done_q, train_done_d;
  logic                 train_fail_q, train_fail_d;
  logic [NUM_LANES-1:0] fail_mask_q, fail_mask_d;
  logic [RW-1:0]        retry_cnt_q, retry_cnt_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 wait_tc, settle_tc;

  // Each timer is held cleared outside its own state, so it reads zero on entry.
  lvds_align_timer #(.WIDTH(TW), .TERMINAL(TIMEOUT_CYCLES - 1)) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_WAIT),
    .en  (state_q == ST_WAIT),
    .tc  (wait_tc)
  );

  lvds_align_timer #(.WIDTH(SW), .TERMINAL(SETTLE_CYCLES - 1)) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_SETTLE),
    .en  (state_q == ST_SETTLE),
    .tc  (settle_tc)
  );

  always_comb begin
    state_d      = state_q;
    lane_start_d = lane_start_q;
    busy_d       = busy_q;
    train_done_d = train_done_q;
    train_fail_d = train_fail_q;
    fail_mask_d  = fail_mask_q;
    retry_cnt_d  = retry_cnt_q;
    lock_lost_d  = lock_lost_q;

    if (state_q != ST_IDLE && !train_req) begin
      // retry_cnt is left visible for the link controller after an abort.
      state_d      = ST_IDLE;
      lane_start_d = '0;
      busy_d       = 1'b0;
      train_done_d = 1'b0;
      train_fail_d = 1'b0;
      fail_mask_d  = '0;
      lock_lost_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (train_req) begin
            state_d      = ST_WAIT;
            lane_start_d = ALL_ONES;
            retry_cnt_d  = '0;
            busy_d       = 1'b1;
          end
        end
        ST_WAIT: begin
          if (&lane_lock) begin
            state_d      = ST_DONE;
            train_done_d = 1'b1;
            busy_d       = 1'b0;
            lane_start_d = ALL_ONES;
          end else if (wait_tc) begin
            if (retry_cnt_q == RW'(MAX_RETRY)) begin
              state_d      = ST_FAIL;
              train_fail_d = 1'b1;
              fail_mask_d  = ~lane_lock;
              lane_start_d = '0;
              busy_d       = 1'b0;
            end else begin
              state_d      = ST_SETTLE;
              lane_start_d = lane_start_q & lane_lock;
              retry_cnt_d  = retry_cnt_q + RW'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (settle_tc) begin
            state_d      = ST_WAIT;
            lane_start_d = ALL_ONES;
          end
        end
        ST_DONE: begin
          if (!(&lane_lock)) begin
            lock_lost_d = 1'b1;
`ifdef LVDS_ALIGN_RELOCK_EN
            state_d      = ST_SETTLE;
            train_done_d = 1'b0;
            busy_d       = 1'b1;
            lane_start_d = lane_start_q & lane_lock;
            retry_cnt_d  = '0;
`endif
          end
        end
        ST_FAIL: begin
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lane_start_q <= '0;
      busy_q       <= 1'b0;
      train_done_q <= 1'b0;
      train_fail_q <= 1'b0;
      fail_mask_q  <= '0;
      retry_cnt_q  <= '0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_start_q <= lane_start_d;
      busy_q       <= busy_d;
      train_done_q <= train_done_d;
      train_fail_q <= train_fail_d;
      fail_mask_q  <= fail_mask_d;
      retry_cnt_q  <= retry_cnt_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign lane_start = lane_start_q;
  assign busy       = busy_q;
  assign train_done = train_done_q;
  assign train_fail = train_fail_q;
  assign fail_mask  = fail_mask_q;
  assign retry_cnt  = retry_cnt_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// tb/tb_lvds_align_ctrl.sv - scoreboard bench for lvds_align_ctrl (LVDS_ALIGN_RELOCK_EN aware)
module tb_lvds_align_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       train_req = 1'b0;
  logic [3:0] lane_lock = 4'h0;
  logic [3:0] lane_start;
  logic       busy, train_done, train_fail, lock_lost;
  logic [3:0] fail_mask;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  lvds_align_ctrl #(
    .NUM_LANES(4), .TIMEOUT_CYCLES(16), .MAX_RETRY(2), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .train_req(train_req), .lane_lock(lane_lock),
    .lane_start(lane_start), .busy(busy), .train_done(train_done),
    .train_fail(train_fail), .fail_mask(fail_mask), .retry_cnt(retry_cnt),
    .lock_lost(lock_lost)
  );

  // {lane_start, busy, train_done, train_fail, fail_mask, retry_cnt, lock_lost}
  function automatic logic [13:0] snap();
    return {lane_start, busy, train_done, train_fail, fail_mask, retry_cnt, lock_lost};
  endfunction

  function automatic logic [13:0] mk(input logic [3:0] ls, input logic b, input logic d,
                                     input logic f, input logic [3:0] m, input logic [1:0] r,
                                     input logic l);
    return {ls, b, d, f, m, r, l};
  endfunction

  task automatic push(input logic [13:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (snap() !== 14'h0) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", snap(), 14'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (snap() !== 14'h0) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", snap(), 14'h0);
    end
  endtask

  task automatic test_basic_lock();
    logic [13:0] e;
    string t;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
        if (snap() !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", t, snap(), e);
        end
      end
      if (k <= 11) begin
        train_req = (k <= 10);
        lane_lock = (k >= 6) ? 4'hF : 4'h0;
        if (k == 11) e = 14'h0;
        else if (k + 1 <= 6) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0);
        else e = mk(4'hF, 0, 1, 0, 4'h0, 2'd0, 0);
        push(e, $sformatf("basic_c%0d", k + 1));
      end
    end
    lane_lock = 4'h0;
  endtask

  task automatic test_retry_fail();
    logic [13:0] e;
    string t;
    int c, a, idx;
    for (int k = 0; k <= 62; k++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
        if (snap() !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", t, snap(), e);
        end
      end
      if (k <= 61) begin
        train_req = (k <= 60);
        lane_lock = (k >= 5) ? 4'b1011 : 4'h0;
        c = k + 1;
        if (k == 61) e = mk(4'h0, 0, 0, 0, 4'h0, 2'd2, 0);
        else if (c >= 57) e = mk(4'h0, 0, 0, 1, 4'b0100, 2'd2, 0);
        else begin
          a = (c - 1) / 20;
          idx = (c - 1) % 20;
          if (idx < 16) e = mk(4'hF, 1, 0, 0, 4'h0, 2'(a), 0);
          else e = mk(4'hB, 1, 0, 0, 4'h0, 2'(a + 1), 0);
        end
        push(e, $sformatf("fail_c%0d", c));
      end
    end
    lane_lock = 4'h0;
  endtask

  task automatic test_second_attempt();
    logic [13:0] e;
    string t;
    int c;
    for (int k = 0; k <= 31; k++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
        if (snap() !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", t, snap(), e);
        end
      end
      if (k <= 30) begin
        train_req = (k <= 29);
        lane_lock = (k < 3) ? 4'h0 : (k < 25) ? 4'b1101 : 4'hF;
        c = k + 1;
        if (k == 30) e = mk(4'h0, 0, 0, 0, 4'h0, 2'd1, 0);
        else if (c <= 16) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0);
        else if (c <= 20) e = mk(4'hD, 1, 0, 0, 4'h0, 2'd1, 0);
        else if (c <= 25) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd1, 0);
        else e = mk(4'hF, 0, 1, 0, 4'h0, 2'd1, 0);
        push(e, $sformatf("relock2_c%0d", c));
      end
    end
    lane_lock = 4'h0;
  endtask

  task automatic test_abort();
    logic [13:0] e;
    string t;
    int c;
    for (int k = 0; k <= 37; k++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
        if (snap() !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", t, snap(), e);
        end
      end
      if (k <= 36) begin
        train_req = (k < 29) || (k >= 31 && k <= 35);
        lane_lock = 4'h0;
        c = k + 1;
        if (c <= 16) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0);
        else if (c <= 20) e = mk(4'h0, 1, 0, 0, 4'h0, 2'd1, 0);
        else if (c <= 29) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd1, 0);
        else if (c <= 31) e = mk(4'h0, 0, 0, 0, 4'h0, 2'd1, 0);
        else if (c <= 36) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0);
        else e = mk(4'h0, 0, 0, 0, 4'h0, 2'd0, 0);
        push(e, $sformatf("abort_c%0d", c));
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [13:0] e;
    string t;
    int c;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
        if (snap() !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", t, snap(), e);
        end
      end
      if (k <= 15) begin
        train_req = (k <= 14);
        lane_lock = (k < 2) ? 4'h0 : (k == 6) ? 4'b0111 : 4'hF;
        c = k + 1;
        if (k == 15) e = 14'h0;
        else if (c <= 2) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0);
        else if (c <= 6) e = mk(4'hF, 0, 1, 0, 4'h0, 2'd0, 0);
`ifdef LVDS_ALIGN_RELOCK_EN
        else if (c <= 10) e = mk(4'h7, 1, 0, 0, 4'h0, 2'd0, 1);
        else if (c == 11) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 1);
        else e = mk(4'hF, 0, 1, 0, 4'h0, 2'd0, 1);
`else
        else e = mk(4'hF, 0, 1, 0, 4'h0, 2'd0, 1);
`endif
        push(e, $sformatf("lockloss_c%0d", c));
      end
    end
    lane_lock = 4'h0;
  endtask

  task automatic test_async_reset();
    logic [13:0] e;
    string t;
    int c;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
        if (snap() !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", t, snap(), e);
        end
      end
      if (k <= 17) begin
        train_req = 1'b1;
        lane_lock = 4'h0;
        c = k + 1;
        if (c <= 16) e = mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0);
        else e = mk(4'h0, 1, 0, 0, 4'h0, 2'd1, 0);
        push(e, $sformatf("arst_c%0d", c));
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (snap() !== 14'h0) begin
      failures++;
      $display("FAIL arst_immediate got=%h exp=%h", snap(), 14'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    push(mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0), "arst_restart0");
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); t = tag_q.pop_front(); checks++;
        if (snap() !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", t, snap(), e);
        end
      end
      if (j < 2) push(mk(4'hF, 1, 0, 0, 4'h0, 2'd0, 0), $sformatf("arst_restart%0d", j + 1));
      else if (j == 2) begin
        train_req = 1'b0;
        push(14'h0, "arst_release");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_retry_fail();
    test_second_attempt();
    test_abort();
    test_lock_loss();
    test_async_reset();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
